xor_reduce_pipe: RTL and testbench

XOR_REDUCE_PIPE -- requirements
Module: xor_reduce_pipe

---
 rtl/xor_reduce_pipe.sv | 177 +++++++++++++++++
 tb/tb_xor_reduce_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_reduce_pipe.sv
// xor_reduce_pipe: pipelined XOR reduction of INPUTS lanes through a registered
// FANIN-ary tree, followed by an output/accumulator stage with valid/ready flow
// control. Optional Keccak-theta mode enabled by defining XOR_REDUCE_ROTATE_EN.
module xor_reduce_pipe #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned INPUTS = 5,
   parameter int unsigned FANIN  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [INPUTS*WIDTH-1:0]   in_data,
   input  logic                      in_accum,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data
);

   // Number of registered tree levels: ceil(log_FANIN(INPUTS)).
   function automatic int unsigned calc_stages();
      int unsigned n;
      int unsigned s;
      n = INPUTS;
      s = 0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (n > 1) begin
            n = (n + FANIN - 1) / FANIN;
            s++;
         end
      end
      return s;
   endfunction

   // Live node count in registered level lvl (0 = first register level).
   function automatic int unsigned nodes_at(int unsigned lvl);
      int unsigned n;
      n = INPUTS;
      for (int unsigned i = 0; i < 16; i++) begin
         if (i <= lvl) n = (n + FANIN - 1) / FANIN;
      end
      return n;
   endfunction

   localparam int unsigned STAGES = calc_stages();
   localparam int unsigned SPAN   = INPUTS * FANIN;

   logic [WIDTH-1:0]  lvl     [STAGES][SPAN];
   logic [WIDTH-1:0]  node_d  [STAGES][INPUTS];
   logic [WIDTH-1:0]  node_q  [STAGES][INPUTS];
   logic [STAGES-1:0] tag_vld_q;
   logic [STAGES-1:0] tag_acc_q;
   logic [STAGES-1:0] tag_lst_q;

   logic [WIDTH-1:0]  t_cur;
   logic [WIDTH-1:0]  t_val;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              en;

   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign t_cur     = node_q[STAGES-1][0];

   // Tree level inputs are zero-padded to SPAN so every node reads FANIN slots;
   // unused slots contribute zero to the XOR.
   always_comb begin
      lvl    = '{default: '0};
      node_d = '{default: '0};
      for (int unsigned k = 0; k < INPUTS; k++) begin
         lvl[0][k] = in_data[k*WIDTH +: WIDTH];
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
         for (int unsigned j = 0; j < INPUTS; j++) begin
            lvl[s][j] = node_q[s-1][j];
         end
      end
      for (int unsigned s = 0; s < STAGES; s++) begin
         for (int unsigned j = 0; j < INPUTS; j++) begin
            if (j < nodes_at(s)) begin
               for (int unsigned f = 0; f < FANIN; f++) begin
                  node_d[s][j] = node_d[s][j] ^ lvl[s][j*FANIN+f];
               end
            end
         end
      end
   end

   // Tree registers and side-band tags advance together, only when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         node_q    <= '{default: '0};
         tag_vld_q <= '0;
         tag_acc_q <= '0;
         tag_lst_q <= '0;
      end else if (en) begin
         node_q       <= node_d;
         tag_vld_q[0] <= in_valid;
         tag_acc_q[0] <= in_accum;
         tag_lst_q[0] <= in_last;
         for (int unsigned s = 1; s < STAGES; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_acc_q[s] <= tag_acc_q[s-1];
            tag_lst_q[s] <= tag_lst_q[s-1];
         end
      end
   end

`ifdef XOR_REDUCE_ROTATE_EN
   logic [WIDTH-1:0] tprev_q, tprev_d;

   // Previous in-group tree value; cleared when a group closes.
   always_comb begin
      tprev_d = tprev_q;
      if (en && tag_vld_q[STAGES-1] && tag_acc_q[STAGES-1]) begin
         tprev_d = tag_lst_q[STAGES-1] ? '0 : t_cur;
      end
   end

   // Previous-T register for theta mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tprev_q <= '0;
      else        tprev_q <= tprev_d;
   end

   // Theta value: rotl(T,1), folded with the previous in-group T for group beats.
   always_comb begin
      t_val = (t_cur << 1) | (t_cur >> (WIDTH-1));
      if (tag_acc_q[STAGES-1]) t_val = t_val ^ tprev_q;
   end
`else
   // Pure XOR mode: the tree result is used unchanged.
   always_comb begin
      t_val = t_cur;
   end
`endif

   // Output/accumulator stage next-state; in_last is only honoured on group beats.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      if (en) begin
         if (!tag_vld_q[STAGES-1]) begin
            out_valid_d = 1'b0;
         end else if (!tag_acc_q[STAGES-1]) begin
            out_data_d  = t_val;
            out_valid_d = 1'b1;
         end else if (!tag_lst_q[STAGES-1]) begin
            sum_d       = sum_q ^ t_val;
            out_valid_d = 1'b0;
         end else begin
            out_data_d  = sum_q ^ t_val;
            out_valid_d = 1'b1;
            sum_d       = '0;
         end
      end
   end

   // Output/accumulator state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
      end
   end

endmodule

// File: tb/tb_xor_reduce_pipe.sv
// Testbench for xor_reduce_pipe: default configuration plus a 9-lane, fan-in 3
// instance, checked against a scoreboard fed with expected results at acceptance.
module tb_xor_reduce_pipe;

   localparam int unsigned W  = 64;
   localparam int unsigned N  = 5;
   localparam int unsigned F  = 2;
   localparam int unsigned W9 = 16;
   localparam int unsigned N9 = 9;
   localparam int unsigned F9 = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid, in_ready, in_accum, in_last;
   logic [N*W-1:0]    in_data;
   logic              out_valid, out_ready;
   logic [W-1:0]      out_data;

   logic              in9_valid, in9_ready, in9_accum, in9_last;
   logic [N9*W9-1:0]  in9_data;
   logic              out9_valid, out9_ready;
   logic [W9-1:0]     out9_data;

   int                checks   = 0;
   int                failures = 0;
   int unsigned       lat, lat9;
   logic [W-1:0]      sb[$];
   logic [W-1:0]      m_acc;

   always #5 clk = ~clk;

   xor_reduce_pipe #(.WIDTH(W), .INPUTS(N), .FANIN(F)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_accum(in_accum), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   xor_reduce_pipe #(.WIDTH(W9), .INPUTS(N9), .FANIN(F9)) u_dut9 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in9_valid), .in_ready(in9_ready), .in_data(in9_data),
      .in_accum(in9_accum), .in_last(in9_last),
      .out_valid(out9_valid), .out_ready(out9_ready), .out_data(out9_data)
   );

   function automatic int unsigned tree_depth(int unsigned n, int unsigned f);
      int unsigned s = 0;
      while (n > 1) begin
         n = (n + f - 1) / f;
         s++;
      end
      return s;
   endfunction

   function automatic logic [N*W-1:0] pack5(input logic [W-1:0] a, b, c, d, e);
      return {e, d, c, b, a};
   endfunction

   function automatic logic [W-1:0] lanes_xor(input logic [N*W-1:0] d);
      logic [W-1:0] t = '0;
      for (int k = 0; k < N; k++) t ^= d[k*W +: W];
      return t;
   endfunction

   // Reference model: called for each accepted beat, pushes expected outputs.
   task automatic model_accept(input logic [N*W-1:0] d, input logic a, input logic l);
      logic [W-1:0] t;
      t = lanes_xor(d);
      if (!a) sb.push_back(t);
      else if (!l) m_acc ^= t;
      else begin
         sb.push_back(m_acc ^ t);
         m_acc = '0;
      end
   endtask

   // One cycle: drive just after posedge, sample at negedge, return to posedge+1.
   task automatic step(input logic v, input logic a, input logic l, input logic [N*W-1:0] d,
                       input logic ordy, output logic acc_ok, output logic got, output logic [W-1:0] q);
      in_valid  = v;
      in_accum  = a;
      in_last   = l;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      acc_ok = v && in_ready;
      got    = out_valid && out_ready;
      q      = out_data;
      if (acc_ok) model_accept(d, a, l);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_accum = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      in9_valid = 1'b0; in9_accum = 1'b0; in9_last = 1'b0; in9_data = '0; out9_ready = 1'b1;
      sb.delete();
      m_acc = '0;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out9_valid !== 1'b0) begin failures++; $display("FAIL reset_out9_valid: got %b expected 0", out9_valid); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic ok, got;
      logic [W-1:0] q, exp_v;
      logic [N*W-1:0] d;
      int lat_seen = -1;
      int n_acc = 0;
      d = pack5(64'd1, 64'd2, 64'd4, 64'd8, 64'd16);
      for (int i = 0; i < 12; i++) begin
         step(i == 0, 1'b0, 1'b0, d, 1'b1, ok, got, q);
         if (i == 0) begin
            checks++;
            if (ok !== 1'b1) begin failures++; $display("FAIL basic_accept: got %b expected 1", ok); end
         end
         if (got && lat_seen < 0) begin
            lat_seen = i;
            checks++;
            if (q !== 64'h1F) begin failures++; $display("FAIL basic_value: got %h expected 1f", q); end
         end
         if (got) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL basic_out: got %h expected none", q); end
            else begin
               exp_v = sb.pop_front();
               if (q !== exp_v) begin failures++; $display("FAIL basic_out: got %h expected %h", q, exp_v); end
            end
         end
      end
      checks++;
      if (lat_seen != int'(lat)) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat_seen, lat); end
      // sustained throughput; in_last on a non-accumulate beat must be ignored
      for (int i = 0; i < 6 + int'(lat) + 3; i++) begin
         d = pack5({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom});
         step(i < 6, 1'b0, i == 3, d, 1'b1, ok, got, q);
         if (ok) n_acc++;
         if (got) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL stream_out: got %h expected none", q); end
            else begin
               exp_v = sb.pop_front();
               if (q !== exp_v) begin failures++; $display("FAIL stream_out: got %h expected %h", q, exp_v); end
            end
         end
      end
      checks++;
      if (n_acc != 6) begin failures++; $display("FAIL stream_throughput: got %0d accepted expected 6", n_acc); end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL stream_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_accum();
      logic ok, got;
      logic [W-1:0] q, exp_v, last_q;
      logic [W-1:0] tv[3];
      int idx = 0;
      int n_out = 0;
      tv[0] = 64'hF0; tv[1] = 64'h0F; tv[2] = 64'hFF;
      last_q = '1;
      for (int i = 0; i < 3 + int'(lat) + 4; i++) begin
         if (idx < 3) step(1'b1, 1'b1, idx == 2, pack5(tv[idx] ^ 64'h3C, '0, '0, '0, 64'h3C), 1'b1, ok, got, q);
         else         step(1'b0, 1'b0, 1'b0, '0, 1'b1, ok, got, q);
         if (ok) idx++;
         if (got) begin
            n_out++;
            last_q = q;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL accum_out: got %h expected none", q); end
            else begin
               exp_v = sb.pop_front();
               if (q !== exp_v) begin failures++; $display("FAIL accum_out: got %h expected %h", q, exp_v); end
            end
         end
      end
      checks++;
      if (n_out != 1) begin failures++; $display("FAIL accum_count: got %0d outputs expected 1", n_out); end
      checks++;
      if (last_q !== 64'h0) begin failures++; $display("FAIL accum_value: got %h expected 0", last_q); end
   endtask

   task automatic test_back_to_back();
      logic ok, got, stall;
      logic [W-1:0] q, exp_v;
      logic [N*W-1:0] tab[8];
      int idx = 0;
      int n_out = 0;
      for (int b = 0; b < 8; b++)
         tab[b] = pack5({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                        {$urandom, $urandom}, {$urandom, $urandom});
      for (int i = 0; i < 30; i++) begin
         stall = (i >= int'(lat) + 1) && (i <= int'(lat) + 3);
         if (idx < 8) step(1'b1, 1'b0, 1'b0, tab[idx], !stall, ok, got, q);
         else         step(1'b0, 1'b0, 1'b0, '0, !stall, ok, got, q);
         if (stall) begin
            checks++;
            if (ok !== 1'b0) begin failures++; $display("FAIL b2b_ready_stall: step %0d got accept %b expected 0", i, ok); end
         end
         if (ok) idx++;
         if (got) begin
            n_out++;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL b2b_out: got %h expected none", q); end
            else begin
               exp_v = sb.pop_front();
               if (q !== exp_v) begin failures++; $display("FAIL b2b_out: got %h expected %h", q, exp_v); end
            end
         end
      end
      checks++;
      if (n_out != 8) begin failures++; $display("FAIL b2b_count: got %0d outputs expected 8", n_out); end
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); end
   endtask

   task automatic test_interleave();
      logic ok, got;
      logic [W-1:0] q, exp_v;
      logic [W-1:0] tv[3];
      logic         av[3];
      logic         lv[3];
      logic [W-1:0] seen[$];
      int idx = 0;
      tv[0] = 64'hAA; av[0] = 1'b1; lv[0] = 1'b0;
      tv[1] = 64'h11; av[1] = 1'b0; lv[1] = 1'b1;
      tv[2] = 64'h55; av[2] = 1'b1; lv[2] = 1'b1;
      for (int i = 0; i < 3 + int'(lat) + 4; i++) begin
         if (idx < 3) step(1'b1, av[idx], lv[idx], pack5('0, tv[idx], '0, '0, '0), 1'b1, ok, got, q);
         else         step(1'b0, 1'b0, 1'b0, '0, 1'b1, ok, got, q);
         if (ok) idx++;
         if (got) begin
            seen.push_back(q);
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL inter_out: got %h expected none", q); end
            else begin
               exp_v = sb.pop_front();
               if (q !== exp_v) begin failures++; $display("FAIL inter_out: got %h expected %h", q, exp_v); end
            end
         end
      end
      checks++;
      if (seen.size() != 2) begin failures++; $display("FAIL inter_count: got %0d outputs expected 2", seen.size()); end
      else begin
         checks++;
         if (seen[0] !== 64'h11 || seen[1] !== 64'hFF)
            begin failures++; $display("FAIL inter_values: got %h,%h expected 11,ff", seen[0], seen[1]); end
      end
   endtask

   task automatic test_reset_mid();
      logic ok, got;
      logic [W-1:0] q, exp_v, last_q;
      logic [W-1:0] tv[3];
      logic         av[3];
      int idx = 0;
      int n_out = 0;
      bit held = 0;
      tv[0] = 64'h12; av[0] = 1'b1;
      tv[1] = 64'h34; av[1] = 1'b1;
      tv[2] = 64'h77; av[2] = 1'b0;
      for (int i = 0; i < 12 && !held; i++) begin
         if (idx < 3) step(1'b1, av[idx], 1'b0, pack5(tv[idx], '0, '0, '0, '0), 1'b0, ok, got, q);
         else         step(1'b0, 1'b0, 1'b0, '0, 1'b0, ok, got, q);
         if (ok) idx++;
         if (idx == 3 && out_valid === 1'b1) held = 1;
      end
      checks++;
      if (!held) begin failures++; $display("FAIL rmid_fill: got out_valid %b expected 1 within bound", out_valid); end
      checks++;
      if (out_data !== 64'h77) begin failures++; $display("FAIL rmid_held: got %h expected 77", out_data); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_async_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin failures++; $display("FAIL rmid_async_data: got %h expected 0", out_data); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
      sb.delete();
      m_acc = '0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idx = 0;
      last_q = '1;
      for (int i = 0; i < int'(lat) + 5; i++) begin
         if (idx < 1) step(1'b1, 1'b1, 1'b1, pack5(64'h30, 64'h0C, '0, '0, '0), 1'b1, ok, got, q);
         else         step(1'b0, 1'b0, 1'b0, '0, 1'b1, ok, got, q);
         if (ok) idx++;
         if (got) begin
            n_out++;
            last_q = q;
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL rmid_out: got %h expected none", q); end
            else begin
               exp_v = sb.pop_front();
               if (q !== exp_v) begin failures++; $display("FAIL rmid_out: got %h expected %h", q, exp_v); end
            end
         end
      end
      checks++;
      if (n_out != 1 || last_q !== 64'h3C)
         begin failures++; $display("FAIL rmid_result: got %0d outputs last %h expected 1 output 3c", n_out, last_q); end
   endtask

   task automatic test_cfg9();
      logic [W9-1:0] q9[$];
      logic [W9-1:0] seen[$];
      logic [W9-1:0] exp_v;
      logic [N9*W9-1:0] d1, d2;
      int first = -1;
      d1 = '1;
      d2 = '0;
      for (int k = 0; k < N9; k++) d2[k*W9 +: W9] = W9'(1) << k;
      for (int i = 0; i < 10; i++) begin
         in9_valid = (i < 2);
         in9_accum = 1'b0;
         in9_last  = 1'b0;
         in9_data  = (i == 0) ? d1 : d2;
         @(negedge clk);
         if (in9_valid && in9_ready) q9.push_back(i == 0 ? 16'hFFFF : 16'h01FF);
         if (out9_valid && out9_ready) begin
            if (first < 0) first = i;
            seen.push_back(out9_data);
            checks++;
            if (q9.size() == 0) begin failures++; $display("FAIL cfg9_out: got %h expected none", out9_data); end
            else begin
               exp_v = q9.pop_front();
               if (out9_data !== exp_v) begin failures++; $display("FAIL cfg9_out: got %h expected %h", out9_data, exp_v); end
            end
         end
         @(posedge clk);
         #1;
      end
      in9_valid = 1'b0;
      checks++;
      if (first != int'(lat9)) begin failures++; $display("FAIL cfg9_latency: got %0d expected %0d", first, lat9); end
      checks++;
      if (seen.size() != 2) begin failures++; $display("FAIL cfg9_count: got %0d outputs expected 2", seen.size()); end
   endtask

   initial begin
      lat  = tree_depth(N, F) + 1;
      lat9 = tree_depth(N9, F9) + 1;
      test_reset();
      test_basic();
      test_accum();
      test_back_to_back();
      test_interleave();
      test_reset_mid();
      test_cfg9();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
